// File: rtl/mult_div_unit_pkg.sv
// Op codes, FSM states and op decode for the HI/LO multiply/divide engine.
// MULT_DIV_ACC_EN adds MADD/MADDU/MSUB/MSUBU and widens op to 4 bits.
package mult_div_unit_pkg;

    localparam int MD_DATA_WIDTH = 32;

`ifdef MULT_DIV_ACC_EN
    localparam int OP_W = 4;
`else
    localparam int OP_W = 3;
`endif

    typedef logic [OP_W-1:0] md_op_t;

    localparam md_op_t MD_MULT  = md_op_t'(0);
    localparam md_op_t MD_MULTU = md_op_t'(1);
    localparam md_op_t MD_DIV   = md_op_t'(2);
    localparam md_op_t MD_DIVU  = md_op_t'(3);
    localparam md_op_t MD_MTHI  = md_op_t'(4);
    localparam md_op_t MD_MTLO  = md_op_t'(5);
`ifdef MULT_DIV_ACC_EN
    localparam md_op_t MD_MADD  = md_op_t'(6);
    localparam md_op_t MD_MADDU = md_op_t'(7);
    localparam md_op_t MD_MSUB  = md_op_t'(8);
    localparam md_op_t MD_MSUBU = md_op_t'(9);
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    typedef struct packed {
        logic go;
        logic sgn;
        logic dv;
`ifdef MULT_DIV_ACC_EN
        logic ac;
        logic sub;
`endif
    } md_dec_t;

    function automatic md_dec_t md_decode(input md_op_t op);
        md_dec_t d;
        d = '0;
        d.go = 1'b1;
        case (op)
            MD_MULT:  d.sgn = 1'b1;
            MD_MULTU: d.go = 1'b1;
            MD_DIV:   begin d.sgn = 1'b1; d.dv = 1'b1; end
            MD_DIVU:  d.dv = 1'b1;
`ifdef MULT_DIV_ACC_EN
            MD_MADD:  begin d.sgn = 1'b1; d.ac = 1'b1; end
            MD_MADDU: d.ac = 1'b1;
            MD_MSUB:  begin d.sgn = 1'b1; d.ac = 1'b1; d.sub = 1'b1; end
            MD_MSUBU: begin d.ac = 1'b1; d.sub = 1'b1; end
`endif
            default:  d.go = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the pipeline and the mult/div engine.
// Op width follows MULT_DIV_ACC_EN through the package.
interface mult_div_unit_if
    import mult_div_unit_pkg::*;
#(
    parameter int DW = MD_DATA_WIDTH
) ();
    logic          start;
    md_op_t        op;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          busy;
    logic          done;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit_md_iter_core.sv
// One combinational iteration: radix-2 shift-add or restoring subtract.
// Multiply keeps the product in {acc, opnd}; divide shifts quotient into opnd.
module md_iter_core #(
    parameter int W = 32
) (
    input  logic         div_i,
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] opnd_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] opnd_o
);
    logic [W:0]   sum;
    logic [W:0]   psel;
    logic [W:0]   shl;
    logic [W-1:0] diff;
    logic         q_bit;

    assign sum   = {1'b0, acc_i} + {1'b0, b_i};
    assign psel  = opnd_i[0] ? sum : {1'b0, acc_i};
    assign shl   = {acc_i, opnd_i[W-1]};
    assign diff  = shl[W-1:0] - b_i;
    assign q_bit = (shl >= {1'b0, b_i});

    always_comb begin
        if (div_i) begin
            acc_o  = q_bit ? diff : shl[W-1:0];
            opnd_o = {opnd_i[W-2:0], q_bit};
        end else begin
            acc_o  = psel[W:1];
            opnd_o = {psel[0], opnd_i[W-1:1]};
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO.
// MULT_DIV_ACC_EN enables MADD/MADDU/MSUB/MSUBU accumulation into {hi,lo}.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = MD_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] DIV0_LO    = '1
) (
    input logic            clock,
    input logic            reset_n,
    mult_div_unit_if.slave md
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W) + 1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic             neg_q, neg_d;
    logic             sa_q, sa_d;
    logic             div_q, div_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
`ifdef MULT_DIV_ACC_EN
    logic             mac_q, mac_d;
    logic             sub_q, sub_d;
    logic [2*W-1:0]   hl_acc;
`endif

    md_dec_t        dec;
    logic           sgn_a, sgn_b;
    logic [W-1:0]   abs_a, abs_b;
    logic [W-1:0]   it_acc, it_opnd;
    logic [W-1:0]   quo, rem;
    logic [2*W-1:0] prod;

    assign dec   = md_decode(md.op);
    assign sgn_a = dec.sgn & md.rs_data[W-1];
    assign sgn_b = dec.sgn & md.rt_data[W-1];
    assign abs_a = sgn_a ? -md.rs_data : md.rs_data;
    assign abs_b = sgn_b ? -md.rt_data : md.rt_data;

    // Remainder follows the dividend sign, quotient the sign product.
    assign prod = neg_q ? -{acc_q, opnd_q} : {acc_q, opnd_q};
    assign quo  = neg_q ? -opnd_q : opnd_q;
    assign rem  = sa_q ? -acc_q : acc_q;
`ifdef MULT_DIV_ACC_EN
    assign hl_acc = sub_q ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod;
`endif

    md_iter_core #(.W(W)) u_core (
        .div_i  (div_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .b_i    (b_q),
        .acc_o  (it_acc),
        .opnd_o (it_opnd)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        b_d     = b_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        div_d   = div_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULT_DIV_ACC_EN
        mac_d   = mac_q;
        sub_d   = sub_q;
`endif
        unique case (1'b1)
            state_q == S_IDLE: begin
                if (md.start && dec.go) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_W'(W);
                    acc_d   = '0;
                    opnd_d  = abs_a;
                    b_d     = abs_b;
                    neg_d   = sgn_a ^ sgn_b;
                    sa_d    = sgn_a;
                    div_d   = dec.dv;
                    dz_d    = (md.rt_data == '0);
`ifdef MULT_DIV_ACC_EN
                    mac_d   = dec.ac;
                    sub_d   = dec.sub;
`endif
                end else if (md.start && md.op == MD_MTHI) begin
                    hi_d = md.rs_data;
                end else if (md.start && md.op == MD_MTLO) begin
                    lo_d = md.rs_data;
                end
            end
            state_q == S_RUN: begin
                acc_d  = it_acc;
                opnd_d = it_opnd;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = S_FIN;
            end
            state_q == S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (div_q) begin
                    hi_d = rem;
                    lo_d = dz_q ? DIV0_LO : quo;
                end
`ifdef MULT_DIV_ACC_EN
                else if (mac_q) begin
                    {hi_d, lo_d} = hl_acc;
                end
`endif
                else begin
                    {hi_d, lo_d} = prod;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULT_DIV_ACC_EN
            mac_q   <= 1'b0;
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            div_q   <= div_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
`ifdef MULT_DIV_ACC_EN
            mac_q   <= mac_d;
            sub_q   <= sub_d;
`endif
        end
    end

    assign md.busy = (state_q != S_IDLE);
    assign md.done = done_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against a 64-bit arithmetic model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    int          checks  = 0;
    int          errors  = 0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;

`ifdef MULT_DIV_ACC_EN
    localparam md_op_t ILL = md_op_t'(10);
`else
    localparam md_op_t ILL = md_op_t'(6);
`endif

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .md      (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input md_op_t o,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [63:0] hl);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              ia, ib;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        r  = hl;
        case (o)
            MD_MULT:  r = 64'(sa * sb);
            MD_MULTU: r = ua * ub;
            MD_DIV: begin
                if (b == 0)
                    r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = {32'd0, 32'h8000_0000};
                else
                    r = {32'(ia % ib), 32'(ia / ib)};
            end
            MD_DIVU: begin
                if (b == 0)
                    r = {a, 32'hFFFF_FFFF};
                else
                    r = {a % b, a / b};
            end
`ifdef MULT_DIV_ACC_EN
            MD_MADD:  r = hl + 64'(sa * sb);
            MD_MADDU: r = hl + ua * ub;
            MD_MSUB:  r = hl - 64'(sa * sb);
            MD_MSUBU: r = hl - ua * ub;
`endif
            default: r = hl;
        endcase
        return r;
    endfunction

    task automatic run_op(input md_op_t o, input logic [31:0] a,
                          input logic [31:0] b, input string tag,
                          input bit intrude);
        logic [63:0] exp;
        int          n;
        exp = model(o, a, b, {m_hi, m_lo});
        @(negedge clock);
        bus.start   = 1'b1;
        bus.op      = o;
        bus.rs_data = a;
        bus.rt_data = b;
        @(posedge clock);
        #1;
        bus.start   = 1'b0;
        bus.rs_data = $urandom;
        bus.rt_data = $urandom;
        chk({tag, " busy"}, 64'(bus.busy), 64'd1);
        chk({tag, " done low"}, 64'(bus.done), 64'd0);
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            if (intrude && n == 4) begin
                bus.start   = 1'b1;
                bus.op      = MD_MTHI;
                bus.rs_data = 32'h1234;
            end
            @(posedge clock);
            #1;
            n++;
            bus.start = 1'b0;
            if (intrude && n == 10)
                chk({tag, " hi held"}, 64'(bus.hi), 64'(m_hi));
        end
        chk({tag, " latency"}, 64'(n), 64'd33);
        chk({tag, " hilo"}, {bus.hi, bus.lo}, exp);
        {m_hi, m_lo} = exp;
    endtask

    task automatic mt(input md_op_t o, input logic [31:0] v, input string tag);
        @(negedge clock);
        bus.start   = 1'b1;
        bus.op      = o;
        bus.rs_data = v;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        if (o == MD_MTHI)
            m_hi = v;
        else
            m_lo = v;
        chk({tag, " hilo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
        chk({tag, " busy"}, 64'(bus.busy), 64'd0);
        chk({tag, " done"}, 64'(bus.done), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.rs_data = '0;
        bus.rt_data = '0;
        #1;
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset hi", 64'(bus.hi), 64'd0);
        chk("reset lo", 64'(bus.lo), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max", 1'b0);
        run_op(MD_MULT, 32'hFFFF_FFF9, 32'd3, "mult -7*3", 1'b0);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div -7/2", 1'b0);
        run_op(MD_DIVU, 32'd100, 32'd0, "divu by0", 1'b0);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf", 1'b0);
        run_op(MD_DIV, 32'hFFFF_FF9C, 32'd0, "div neg by0", 1'b0);
        run_op(MD_MULTU, 32'd5, 32'd7, "intrude", 1'b1);

        mt(MD_MTLO, 32'hDEAD_BEEF, "mtlo");
        mt(MD_MTHI, 32'h0BAD_F00D, "mthi");

        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = ILL;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        chk("illegal busy", 64'(bus.busy), 64'd0);
        chk("illegal hilo", {bus.hi, bus.lo}, {m_hi, m_lo});

        for (int i = 0; i < 24; i++)
            run_op(md_op_t'($urandom_range(0, 3)), pick(), pick(),
                   $sformatf("rand%0d", i), 1'b0);

`ifdef MULT_DIV_ACC_EN
        mt(MD_MTHI, 32'd0, "acc hi0");
        mt(MD_MTLO, 32'd5, "acc lo5");
        run_op(MD_MADDU, 32'd2, 32'd3, "maddu", 1'b0);
        run_op(MD_MSUB, 32'hFFFF_FFFE, 32'd7, "msub", 1'b0);
        run_op(MD_MADD, pick(), pick(), "madd rand", 1'b0);
        run_op(MD_MSUBU, pick(), pick(), "msubu rand", 1'b0);
`endif

        @(negedge clock);
        bus.start   = 1'b1;
        bus.op      = MD_DIVU;
        bus.rs_data = 32'd12345;
        bus.rt_data = 32'd7;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        chk("arst busy", 64'(bus.busy), 64'd0);
        chk("arst done", 64'(bus.done), 64'd0);
        chk("arst hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done === 1'b1)
                seen = 1;
        end
        chk("arst no done", 64'(seen), 64'd0);
        chk("arst hilo after", {bus.hi, bus.lo}, {m_hi, m_lo});

        run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, "post rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
